// File: rtl/core_pkg.sv
// Minimal stand-in for the core package: only the operand type used on the
// store/load operand ports of rvv_core.
package core_pkg;

  typedef logic [31:0] vrf_data_t;

endpackage : core_pkg

// File: rtl/vrf_op_loopback.sv
// Memory stand-in: store operands from the core are queued in order and
// handed back as load operands once they have aged by Latency cycles.
module vrf_op_loopback
  import core_pkg::*;
#(
  parameter int unsigned Depth   = 8,
  parameter int unsigned Latency = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       store_op_valid_i,
  input  vrf_data_t                  store_op_i,
  output logic                       store_op_gnt_o,
  output logic                       load_op_valid_o,
  output vrf_data_t                  load_op_o,
  input  logic                       load_op_ready_i,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic [31:0]                stores_total_o,
  output logic [31:0]                loads_total_o
);

  localparam int unsigned AgeW = 4;
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [AgeW-1:0] LatAge   = AgeW'(Latency);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  vrf_data_t       r_data [Depth];
  logic [AgeW-1:0] r_age  [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic [31:0]     r_stores;
  logic [31:0]     r_loads;
  logic            w_push;
  logic            w_pop;

  // No pass-through: a full buffer refuses the store even if the head leaves now.
  assign store_op_gnt_o  = rst_ni && store_op_valid_i && (r_count < DepthCnt) && !flush_i;
  assign w_push          = store_op_gnt_o;
  assign load_op_valid_o = (r_count != '0) && (r_age[r_rd_ptr] >= LatAge);
  assign load_op_o       = load_op_valid_o ? r_data[r_rd_ptr] : '0;
  assign w_pop           = load_op_valid_o && load_op_ready_i;

  assign count_o        = r_count;
  assign stores_total_o = r_stores;
  assign loads_total_o  = r_loads;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= store_op_i;
    end
  end

  // Stale ages of free slots are harmless: a push always restarts the slot at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (w_push && (r_wr_ptr == PtrW'(i))) begin
          r_age[i] <= '0;
        end else if (r_age[i] < LatAge) begin
          r_age[i] <= r_age[i] + AgeW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_stores <= '0;
      r_loads  <= '0;
    end else begin
      if (w_push) begin
        r_stores <= r_stores + 32'd1;
      end
      if (w_pop) begin
        r_loads <= r_loads + 32'd1;
      end
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PtrW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PtrW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CntW'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CntW'(1);
        end
      end
    end
  end

endmodule : vrf_op_loopback

// File: tb/tb_vrf_op_loopback.sv
// Scoreboard bench: the reference is a timestamped queue of accepted stores;
// a store becomes loadable 1+Latency cycles after the cycle it was accepted.
module tb_vrf_op_loopback;
  import core_pkg::*;

  localparam int DEPTH = 8;
  localparam int LAT   = 2;

  typedef struct {
    vrf_data_t d;
    int        t;
  } ent_t;

  logic             clk_i;
  logic             rst_ni;
  logic             flush_i;
  logic             store_op_valid_i;
  vrf_data_t        store_op_i;
  logic             store_op_gnt_o;
  logic             load_op_valid_o;
  vrf_data_t        load_op_o;
  logic             load_op_ready_i;
  logic [3:0]       count_o;
  logic [31:0]      stores_total_o;
  logic [31:0]      loads_total_o;

  vrf_op_loopback #(.Depth(DEPTH), .Latency(LAT)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .store_op_valid_i (store_op_valid_i),
    .store_op_i       (store_op_i),
    .store_op_gnt_o   (store_op_gnt_o),
    .load_op_valid_o  (load_op_valid_o),
    .load_op_o        (load_op_o),
    .load_op_ready_i  (load_op_ready_i),
    .count_o          (count_o),
    .stores_total_o   (stores_total_o),
    .loads_total_o    (loads_total_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int        tests = 0;
  int        fails = 0;
  int        mcyc  = 0;
  int        stores_exp = 0;
  int        loads_exp  = 0;
  ent_t      mq[$];
  vrf_data_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @model_cycle %0d: got %0h expected %0h", name, mcyc, act, exp);
    end
  endtask

  // One clock of stimulus; checks outputs, then advances the reference.
  task automatic step(input logic sv, input vrf_data_t d, input logic rdy, input logic fl);
    bit        gnt_e;
    bit        val_e;
    vrf_data_t dat_e;
    @(negedge clk_i);
    store_op_valid_i = sv;
    store_op_i       = d;
    load_op_ready_i  = rdy;
    flush_i          = fl;
    #2;
    gnt_e = sv && (mq.size() < DEPTH) && !fl;
    val_e = (mq.size() != 0) && (mcyc >= mq[0].t + 1 + LAT);
    dat_e = val_e ? mq[0].d : '0;
    chk("gnt",      64'(store_op_gnt_o),  64'(gnt_e));
    chk("valid",    64'(load_op_valid_o), 64'(val_e));
    chk("load_op",  64'(load_op_o),       64'(dat_e));
    chk("count",    64'(count_o),         64'(mq.size()));
    chk("stores_t", 64'(stores_total_o),  64'(stores_exp));
    chk("loads_t",  64'(loads_total_o),   64'(loads_exp));
    if (val_e && rdy) begin
      void'(mq.pop_front());
      loads_exp++;
    end
    if (fl) begin
      mq.delete();
      sb_q.delete();
    end else if (gnt_e) begin
      mq.push_back('{d: d, t: mcyc});
      sb_q.push_back(d);
      stores_exp++;
    end
    mcyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH + 4 * LAT + 8; i++) begin
      if (mq.size() == 0) break;
      step(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    store_op_valid_i = 1'b0;
    load_op_ready_i  = 1'b0;
    flush_i          = 1'b0;
    #3 rst_ni = 1'b0;
    #1;
    chk("rst_gnt",     64'(store_op_gnt_o),  64'd0);
    chk("rst_valid",   64'(load_op_valid_o), 64'd0);
    chk("rst_load_op", 64'(load_op_o),       64'd0);
    chk("rst_count",   64'(count_o),         64'd0);
    chk("rst_stores",  64'(stores_total_o),  64'd0);
    chk("rst_loads",   64'(loads_total_o),   64'd0);
    mq.delete();
    sb_q.delete();
    stores_exp = 0;
    loads_exp  = 0;
    @(negedge clk_i);
    #3 rst_ni = 1'b1;
  endtask

  // Monitor: every delivered load must be the oldest outstanding store.
  initial begin
    vrf_data_t e;
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_ni && load_op_valid_o && load_op_ready_i) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_underflow: got load %0h expected none", load_op_o);
        end else begin
          e = sb_q.pop_front();
          if (load_op_o !== e) begin
            fails++;
            $display("FAIL sb_data: got %0h expected %0h", load_op_o, e);
          end else begin
            $display("[TB] load %08h ok", load_op_o);
          end
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0;
    store_op_valid_i = 1'b0;
    store_op_i = '0;
    load_op_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("init_count", 64'(count_o),         64'd0);
    chk("init_valid", 64'(load_op_valid_o), 64'd0);
    rst_ni = 1'b1;

    // Reset state, then a single store returning after the latency.
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'hA5, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill to full, hold a 9th store, then pop while full.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, vrf_data_t'(i), 1'b0, 1'b0);
    repeat (3) step(1'b1, 32'd9, 1'b0, 1'b0);
    step(1'b1, 32'd9, 1'b1, 1'b0);
    step(1'b1, 32'd9, 1'b0, 1'b0);
    drain();

    // Streaming store and load every cycle.
    for (int i = 1; i <= 20; i++) step(1'b1, vrf_data_t'(i), 1'b1, 1'b0);
    drain();

    // Flush with three buffered and a store offered in the flush cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + vrf_data_t'(i), 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);

    // Asynchronous reset with five entries buffered.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + vrf_data_t'(i), 1'b0, 1'b0);
    do_reset();
    step(1'b1, 32'h77, 1'b0, 1'b0);
    step(1'b1, 32'h78, 1'b0, 1'b0);
    drain();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), vrf_data_t'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    end
    drain();
    step(1'b0, '0, 1'b0, 1'b0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_vrf_op_loopback
